// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// RISC-V funct3 access-size codes and request legality helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANE_W = 2;

  // Unsigned variants only exist for loads.
  function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return store;
      default:          return 1'b1;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [LANE_W-1:0] lo);
    case (f3)
      F3_W:        return lo != '0;
      F3_H, F3_HU: return lo[0];
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: little-endian load extract/extend and
// sub-word store merge into a previously read memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [LANE_W-1:0] lane,
  input  logic [WORD_W-1:0] word,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_ext,
  output logic [WORD_W-1:0] merged
);

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: BYTE_W];
    half_sel = lane[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load_ext = {{(WORD_W-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
      F3_H:    load_ext = {{(WORD_W-HALF_W){half_sel[HALF_W-1]}}, half_sel};
      F3_BU:   load_ext = {{(WORD_W-BYTE_W){1'b0}}, byte_sel};
      F3_HU:   load_ext = {{(WORD_W-HALF_W){1'b0}}, half_sel};
      default: load_ext = word;
    endcase

    merged = wdata;
    case (funct3)
      F3_B: begin
        merged = word;
        merged[{lane, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
      end
      F3_H: merged = lane[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a word-only data memory with
// read-modify-write sub-word stores. Define LSU_MISALIGN_CHECK_EN to reject
// misaligned word/halfword accesses instead of silently aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_err,
  output logic [31:0]       load_data,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  lsu_state_t        state;
  logic              store_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              req_err;
  logic [ADDR_W-1:0] req_word_addr;
  logic [31:0]       load_ext;
  logic [31:0]       merged;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_W];
  assign req_word_addr    = {req_addr[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGN_CHECK_EN
  assign req_err = f3_illegal(req_store, req_funct3) ||
                   misaligned(req_funct3, req_addr[LANE_W-1:0]);
`else
  assign req_err = f3_illegal(req_store, req_funct3);
`endif

  // Lane logic works on the live read word during READ, so both the load
  // result and the merged store word are registered in that same cycle.
  lsu_lane_align u_lane_align (
    .funct3   (f3_q),
    .lane     (addr_q[LANE_W-1:0]),
    .word     (mem_read_data),
    .wdata    (wdata_q),
    .load_ext (load_ext),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      store_q        <= 1'b0;
      f3_q           <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      load_data      <= '0;
      MemRead        <= 1'b0;
      MemWrite       <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_q   <= req_store;
            f3_q      <= req_funct3;
            addr_q    <= req_addr[ADDR_W-1:0];
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            load_data <= '0;
            resp_err  <= 1'b0;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_store && (req_funct3 == F3_W)) begin
              state          <= WRITE;
              MemWrite       <= 1'b1;
              mem_addr       <= req_word_addr;
              mem_write_data <= req_wdata;
            end else begin
              state    <= READ;
              MemRead  <= 1'b1;
              mem_addr <= req_word_addr;
            end
          end
        end
        READ: begin
          MemRead <= 1'b0;
          if (store_q) begin
            state          <= WRITE;
            MemWrite       <= 1'b1;
            mem_write_data <= merged;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            load_data  <= load_ext;
            mem_addr   <= '0;
          end
        end
        WRITE: begin
          state          <= RESP;
          MemWrite       <= 1'b0;
          mem_addr       <= '0;
          mem_write_data <= '0;
          resp_valid     <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table driven through a
// scoreboard queue, plus backpressure and mid-operation reset sequences.
module tb_load_store_unit;

  localparam int unsigned ADDR_W = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_err;
  logic [31:0]       load_data;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_store      (req_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_err       (resp_err),
    .load_data      (load_data),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  // Data memory: preloaded on the first clock (during reset), then written on MemWrite.
  logic [31:0] mem [0:127];
  bit          loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 128; i++) mem[i] <= i;
      mem[8] <= 32'h80FF7F08;
      loaded <= 1'b1;
    end else if (MemWrite) begin
      mem[mem_addr[8:2]] <= mem_write_data;
    end
  end
  assign mem_read_data = mem[mem_addr[8:2]];

  int unsigned rd_tot = 0;
  int unsigned wr_tot = 0;
  logic [ADDR_W-1:0] last_rd_addr, last_wr_addr;
  logic [31:0]       last_wr_data;
  always @(negedge clk) begin
    if (MemRead) begin
      rd_tot++;
      last_rd_addr = mem_addr;
    end
    if (MemWrite) begin
      wr_tot++;
      last_wr_addr = mem_addr;
      last_wr_data = mem_write_data;
    end
  end

  typedef struct {
    string       name;
    bit          store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    bit          exp_err;
    int unsigned exp_lat;
    int unsigned exp_rd;
    int unsigned exp_wr;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mwdata;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic vec_t mk(string name, bit store, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] exp_data, bit exp_err,
                              int unsigned lat, int unsigned rd, int unsigned wr,
                              logic [31:0] maddr, logic [31:0] mwdata);
    vec_t v;
    v.name = name; v.store = store; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_data = exp_data; v.exp_err = exp_err; v.exp_lat = lat;
    v.exp_rd = rd; v.exp_wr = wr; v.exp_maddr = maddr; v.exp_mwdata = mwdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned rd0, wr0, lat;
    bit got, rdy;
    vec_t e;
    rdy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready) begin rdy = 1'b1; break; end
    end
    chk({v.name, " req_ready"}, {31'd0, rdy}, 32'd1);
    req_store = v.store; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    req_valid = 1'b1;
    rd0 = rd_tot; wr0 = wr_tot;
    exp_q.push_back(v);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      chk({v.name, " rd&wr excl"}, {31'd0, MemRead & MemWrite}, 32'd0);
      if (resp_valid) begin got = 1'b1; break; end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timeout waiting resp_valid", v.name);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      chk({e.name, " latency"}, lat, e.exp_lat);
      chk({e.name, " load_data"}, load_data, e.exp_data);
      chk({e.name, " resp_err"}, {31'd0, resp_err}, {31'd0, e.exp_err});
      chk({e.name, " n_read"}, rd_tot - rd0, e.exp_rd);
      chk({e.name, " n_write"}, wr_tot - wr0, e.exp_wr);
      if (e.exp_rd != 0) chk({e.name, " rd_addr"}, {23'd0, last_rd_addr}, e.exp_maddr);
      if (e.exp_wr != 0) begin
        chk({e.name, " wr_addr"}, {23'd0, last_wr_addr}, e.exp_maddr);
        chk({e.name, " wr_data"}, last_wr_data, e.exp_mwdata);
      end
    end
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] held;
    bit got;
    int unsigned wr0;

    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;

    vecs.push_back(mk("lw 010",  0, 3'b010, 32'h010, 0, 32'h00000004, 0, 2, 1, 0, 32'h010, 0));
    vecs.push_back(mk("lb 021",  0, 3'b000, 32'h021, 0, 32'h0000007F, 0, 2, 1, 0, 32'h020, 0));
    vecs.push_back(mk("lh 022",  0, 3'b001, 32'h022, 0, 32'hFFFF80FF, 0, 2, 1, 0, 32'h020, 0));
    vecs.push_back(mk("lhu 022", 0, 3'b101, 32'h022, 0, 32'h000080FF, 0, 2, 1, 0, 32'h020, 0));
    vecs.push_back(mk("lbu 023", 0, 3'b100, 32'h023, 0, 32'h00000080, 0, 2, 1, 0, 32'h020, 0));
    vecs.push_back(mk("lw hi",   0, 3'b010, 32'hFFFFFE10, 0, 32'h00000004, 0, 2, 1, 0, 32'h010, 0));
    vecs.push_back(mk("sb 021",  1, 3'b000, 32'h021, 32'h000000AB, 0, 0, 3, 1, 1, 32'h020, 32'h80FFAB08));
    vecs.push_back(mk("lb 021b", 0, 3'b000, 32'h021, 0, 32'hFFFFFFAB, 0, 2, 1, 0, 32'h020, 0));
    vecs.push_back(mk("sh 016",  1, 3'b001, 32'h016, 32'h1234BEEF, 0, 0, 3, 1, 1, 32'h014, 32'hBEEF0005));
    vecs.push_back(mk("lw 014",  0, 3'b010, 32'h014, 0, 32'hBEEF0005, 0, 2, 1, 0, 32'h014, 0));
    vecs.push_back(mk("lh 016",  0, 3'b001, 32'h016, 0, 32'hFFFFBEEF, 0, 2, 1, 0, 32'h014, 0));
    vecs.push_back(mk("sw 030",  1, 3'b010, 32'h030, 32'hDEADBEEF, 0, 0, 2, 0, 1, 32'h030, 32'hDEADBEEF));
    vecs.push_back(mk("lw 030",  0, 3'b010, 32'h030, 0, 32'hDEADBEEF, 0, 2, 1, 0, 32'h030, 0));
    vecs.push_back(mk("lb 033",  0, 3'b000, 32'h033, 0, 32'hFFFFFFDE, 0, 2, 1, 0, 32'h030, 0));
    vecs.push_back(mk("lbu 030", 0, 3'b100, 32'h030, 0, 32'h000000EF, 0, 2, 1, 0, 32'h030, 0));
    vecs.push_back(mk("ld f3=3", 0, 3'b011, 32'h010, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("sbu",     1, 3'b100, 32'h010, 32'h55, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("ld f3=6", 0, 3'b110, 32'h010, 0, 0, 1, 1, 0, 0, 0, 0));
`ifdef LSU_MISALIGN_CHECK_EN
    vecs.push_back(mk("lw 013",  0, 3'b010, 32'h013, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("lh 017",  0, 3'b001, 32'h017, 0, 0, 1, 1, 0, 0, 0, 0));
`else
    vecs.push_back(mk("lw 013",  0, 3'b010, 32'h013, 0, 32'h00000004, 0, 2, 1, 0, 32'h010, 0));
    vecs.push_back(mk("lh 017",  0, 3'b001, 32'h017, 0, 32'hFFFFBEEF, 0, 2, 1, 0, 32'h014, 0));
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst load_data", load_data, 32'd0);
    chk("rst MemRead", {31'd0, MemRead}, 32'd0);
    chk("rst MemWrite", {31'd0, MemWrite}, 32'd0);
    chk("rst mem_addr", {23'd0, mem_addr}, 32'd0);
    chk("rst mem_wdata", mem_write_data, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: response held while resp_ready is low; new request ignored.
    @(negedge clk);
    resp_ready = 1'b0;
    req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h020; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resp_valid) begin got = 1'b1; break; end
    end
    chk("bp resp seen", {31'd0, got}, 32'd1);
    held = load_data;
    chk("bp load_data", held, 32'h80FFAB08);
    req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h040; req_wdata = 32'hFFFFFFFF;
    req_valid = 1'b1;
    wr0 = wr_tot;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp data stable", load_data, 32'h80FFAB08);
      chk("bp req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp resp done", {31'd0, resp_valid}, 32'd0);
    chk("bp ready again", {31'd0, req_ready}, 32'd1);
    chk("bp no write", wr_tot - wr0, 32'd0);
    chk("bp word16", mem[16], 32'd16);

    // Reset while the sub-word store is in its read phase.
    req_store = 1'b1; req_funct3 = 3'b001; req_addr = 32'h020; req_wdata = 32'h00005555;
    req_valid = 1'b1;
    wr0 = wr_tot;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rr in READ", {31'd0, MemRead}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rr req_ready", {31'd0, req_ready}, 32'd1);
    chk("rr MemRead", {31'd0, MemRead}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("rr resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rr MemWrite", {31'd0, MemWrite}, 32'd0);
      @(negedge clk);
    end
    chk("rr no write", wr_tot - wr0, 32'd0);
    chk("rr word8", mem[8], 32'h80FFAB08);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
